flit_serializer: RTL and testbench
==================================

Name: flit_serializer

Overview:
- Network-interface transmitter for the serial flit link.
- Takes a parallel packet from the local core and emits it as flit_size-bit flits into a router input port FIFO.
- Packet layout: routing address in bits [address_size-1:0], payload above it. Flits go out LSB nibble first, so the router's current-address shift register holds the full address after address_size/flit_size flits.
- Flow control: write-enable into the downstream FIFO, gated by fifo_full. A one-deep pending buffer allows back-to-back packets with no bubble.

Parameters:
- packet_size, 32, packet width in bits; must be a multiple of flit_size.
- address_size, 16, routing address field width; must be a multiple of flit_size. Documents flit ordering only.
- flit_size, 4, flit width in bits.
- flits_per_packet = packet_size/flit_size (8), derived local parameter. Flit counter width is ceil(log2(flits_per_packet)), i.e. 3.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- packet_valid  input  1  core presents a packet.
- packet_in  input  packet_size  packet data.
- packet_ready  output  1  block can accept a packet this cycle.
- fifo_full  input  1  downstream router input FIFO is full.
- write_fifo  output  1  flit_out is written into the downstream FIFO this cycle.
- flit_out  output  flit_size  current flit.
- busy  output  1  a packet is in the transmit shifter or the pending buffer.
- packet_sent  output  1  one-cycle pulse, registered, high the cycle after the last flit is written.

Behaviour:
- State:
  - pending_reg/pending_valid (one-deep buffer).
  - tx_shift (packet_size bits), tx_count (3 bits), state IDLE/SEND.
- Reset (async, reset==0):
  - state=IDLE; tx_count=0; tx_shift=0; pending_valid=0; pending_reg=0; packet_sent=0.
  - Resulting outputs: packet_ready=1, write_fifo=0, flit_out=0, busy=0.
- packet_ready = !pending_valid, combinational.
- Accept occurs when packet_valid & packet_ready at a rising edge.
- Flit output (combinational from state):
  - flit_out = tx_shift[flit_size-1:0].
  - write_fifo = (state==SEND) & !fifo_full.
- Write cycle (write_fifo=1): tx_shift shifts right by flit_size with zero fill; tx_count increments.
- fifo_full=1 in SEND: tx_shift, tx_count and flit_out hold; no flit is lost or duplicated.
- Last flit: a write with tx_count==flits_per_packet-1.
  - packet_sent=1 next cycle.
  - tx_count returns to 0.
- Shifter load priority, evaluated at each edge:
  1. If (state==IDLE or last flit written this cycle) and pending_valid: tx_shift<=pending_reg, pending_valid<=0, state=SEND.
  2. Else if (state==IDLE or last flit written) and accept: tx_shift<=packet_in, state=SEND; the packet bypasses the pending buffer.
  3. Else if accept: pending_reg<=packet_in, pending_valid<=1.
  4. Else if last flit written: state=IDLE.
- Latency: accept at edge N → first flit on flit_out / write_fifo in cycle N+1 if fifo_full=0.
- Throughput: one packet per flits_per_packet cycles with fifo_full=0; zero idle cycles between consecutive packets.
- Simultaneous last-flit write and pending_valid=1: the pending packet moves to the shifter on that edge. packet_ready was 0, so there is no accept that cycle; packet_ready=1 next cycle.
- Simultaneous last-flit write and accept with pending empty: the new packet loads directly into the shifter.
- packet_in is sampled only on accept; later changes are ignored.
- busy = (state==SEND) | pending_valid.
- Reset mid-packet:
  - Any partially sent packet and the pending packet are discarded; outputs go to reset values immediately (async).
  - The next accepted packet starts at flit 0.

Optional Feature:
- Macro FLIT_SERIALIZER_PKT_COUNT_EN.
- When defined:
  - Adds output sent_count [15:0], reset to 0.
  - Increments on each packet_sent pulse; wraps 0xFFFF→0x0000.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic serialization: after reset release, accept packet_in=0x1234ABCD with fifo_full=0 → write_fifo high 8 consecutive cycles, flit_out=D,C,B,A,4,3,2,1; packet_sent pulses once, the cycle after flit 1; busy=0 afterwards.
- Backpressure: same packet, fifo_full=1 for 2 cycles while flit_out=B → write_fifo=0 for those cycles, flit_out holds B; the remaining sequence B,A,4,3,2,1 follows with no loss or duplicate; 8 writes total.
- Back-to-back: packet_valid held with 0x11112222 then 0x33334444 → 16 consecutive writes (2,2,2,2,1,1,1,1,4,4,4,4,3,3,3,3). packet_ready=0 from the second accept until the first packet's last flit.
- Full at start: fifo_full=1 at accept for 5 cycles → no writes, flit_out=first nibble held; first write the cycle fifo_full drops.
- Reset mid-packet: assert reset after 3 flits of 0xDEADBEEF with a second packet pending → write_fifo=0, flit_out=0, packet_ready=1 immediately. Next packet 0x0000000F emits F,0,0,0,0,0,0,0.
- With FLIT_SERIALIZER_PKT_COUNT_EN: 3 packets sent → sent_count=3. Preload to 0xFFFF via 65535 packets (or force) then one more packet → sent_count=0x0000.

Source files
------------

// File: rtl/flit_serializer_if.sv
// Core-side and router-side signals of the flit serializer, bundled as one interface.
// Optional FLIT_SERIALIZER_PKT_COUNT_EN adds the sent_count output.
interface flit_serializer_if #(
  parameter int packet_size = 32,
  parameter int flit_size   = 4
);

  logic                   packet_valid;
  logic [packet_size-1:0] packet_in;
  logic                   packet_ready;
  logic                   fifo_full;
  logic                   write_fifo;
  logic [flit_size-1:0]   flit_out;
  logic                   busy;
  logic                   packet_sent;
`ifdef FLIT_SERIALIZER_PKT_COUNT_EN
  logic [15:0]            sent_count;
`endif

  // The serializer end of the link.
  modport slave (
    input  packet_valid,
    input  packet_in,
    input  fifo_full,
    output packet_ready,
    output write_fifo,
    output flit_out,
    output busy,
`ifdef FLIT_SERIALIZER_PKT_COUNT_EN
    output sent_count,
`endif
    output packet_sent
  );

  // The core / router end that drives packets and back-pressure.
  modport master (
    output packet_valid,
    output packet_in,
    output fifo_full,
    input  packet_ready,
    input  write_fifo,
    input  flit_out,
    input  busy,
`ifdef FLIT_SERIALIZER_PKT_COUNT_EN
    input  sent_count,
`endif
    input  packet_sent
  );

endinterface

// File: rtl/flit_serializer.sv
// Network-interface transmitter: parallel packet in, LSB-first flits out with a one-deep pending buffer.
// Optional FLIT_SERIALIZER_PKT_COUNT_EN adds a wrapping 16-bit count of packets sent.
module flit_serializer #(
  parameter int packet_size  = 32,
  parameter int address_size = 16,
  parameter int flit_size    = 4
) (
  input  logic              clk,
  input  logic              reset,
  flit_serializer_if.slave  bus
);

  localparam int FLITS = packet_size / flit_size;
  localparam int CNT_W = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam logic [CNT_W-1:0] LAST_FLIT = CNT_W'(FLITS - 1);

  // Elaboration-time sanity checks on the packet geometry.
  if ((packet_size % flit_size) != 0) begin : g_bad_packet
    $error("packet_size must be a multiple of flit_size");
  end
  if ((address_size % flit_size) != 0 || address_size > packet_size) begin : g_bad_address
    $error("address_size must be a multiple of flit_size and fit in the packet");
  end

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 r_state;
  logic [packet_size-1:0] r_tx_shift;
  logic [CNT_W-1:0]       r_tx_count;
  logic [packet_size-1:0] r_pending_reg;
  logic                   r_pending_valid;
  logic                   r_packet_sent;
`ifdef FLIT_SERIALIZER_PKT_COUNT_EN
  logic [15:0]            r_sent_count;
`endif

  logic w_write;
  logic w_last;
  logic w_accept;
  logic w_load_slot;

  assign w_write     = (r_state == SEND) && !bus.fifo_full;
  assign w_last      = w_write && (r_tx_count == LAST_FLIT);
  assign w_accept    = bus.packet_valid && !r_pending_valid;
  assign w_load_slot = (r_state == IDLE) || w_last;

  assign bus.packet_ready = !r_pending_valid;
  assign bus.write_fifo   = w_write;
  assign bus.flit_out     = r_tx_shift[flit_size-1:0];
  assign bus.busy         = (r_state == SEND) || r_pending_valid;
  assign bus.packet_sent  = r_packet_sent;
`ifdef FLIT_SERIALIZER_PKT_COUNT_EN
  assign bus.sent_count   = r_sent_count;
`endif

  // Shift-out on every accepted write; the load priority lets a pending packet
  // (or a bypassing new one) replace the last flit on the same edge, so no bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_tx_shift      <= '0;
      r_tx_count      <= '0;
      r_pending_reg   <= '0;
      r_pending_valid <= 1'b0;
      r_packet_sent   <= 1'b0;
    end else begin
      r_packet_sent <= w_last;

      if (w_write) begin
        r_tx_shift <= r_tx_shift >> flit_size;
        r_tx_count <= w_last ? '0 : r_tx_count + 1'b1;
      end

      if (w_load_slot && r_pending_valid) begin
        r_tx_shift      <= r_pending_reg;
        r_pending_valid <= 1'b0;
        r_state         <= SEND;
      end else if (w_load_slot && w_accept) begin
        r_tx_shift <= bus.packet_in;
        r_state    <= SEND;
      end else if (w_accept) begin
        r_pending_reg   <= bus.packet_in;
        r_pending_valid <= 1'b1;
      end else if (w_last) begin
        r_state <= IDLE;
      end
    end
  end

`ifdef FLIT_SERIALIZER_PKT_COUNT_EN
  // Counts in step with the packet_sent pulse; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sent_count <= '0;
    end else if (w_last) begin
      r_sent_count <= r_sent_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_flit_serializer.sv
// Directed self-checking bench for flit_serializer: serialization, back-pressure,
// back-to-back packets, full-at-start, async reset mid-packet and the optional sent counter.
module tb_flit_serializer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   nChecks = 0;
  int   nPass   = 0;
  int   nWrites;

  logic [3:0] seqA [8]  = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
  logic [3:0] seqB [16] = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h1, 4'h1, 4'h1, 4'h1,
                            4'h4, 4'h4, 4'h4, 4'h4, 4'h3, 4'h3, 4'h3, 4'h3};
  logic [3:0] seqF [8]  = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

  flit_serializer_if #(.packet_size(32), .flit_size(4)) bus();

  flit_serializer #(
    .packet_size (32),
    .address_size(16),
    .flit_size   (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Inputs change on the falling edge; checks happen 1 time unit later.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the summary");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic full);
    bus.packet_valid = valid;
    bus.packet_in    = data;
    bus.fifo_full    = full;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic sendPacket(input logic [31:0] data);
    @(negedge clk);
    applyStimulus(1'b1, data, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 1'b0);
    end
    #1;
    checkOutput("cnt_sent_pulse", {31'b0, bus.packet_sent}, 32'd1);
  endtask

  initial begin
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1 reset = 1'b0;
    #2;
    checkOutput("rst_ready", {31'b0, bus.packet_ready}, 32'd1);
    checkOutput("rst_write", {31'b0, bus.write_fifo}, 32'd0);
    checkOutput("rst_flit",  {28'b0, bus.flit_out}, 32'd0);
    checkOutput("rst_busy",  {31'b0, bus.busy}, 32'd0);
    checkOutput("rst_sent",  {31'b0, bus.packet_sent}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic serialization of 0x1234ABCD.
    @(negedge clk);
    applyStimulus(1'b1, 32'h1234ABCD, 1'b0);
    #1 checkOutput("t1_ready", {31'b0, bus.packet_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("t1_write", {31'b0, bus.write_fifo}, 32'd1);
      checkOutput("t1_flit",  {28'b0, bus.flit_out}, {28'b0, seqA[i]});
      checkOutput("t1_sent",  {31'b0, bus.packet_sent}, 32'd0);
    end
    @(negedge clk); #1;
    checkOutput("t1_sent_pulse", {31'b0, bus.packet_sent}, 32'd1);
    checkOutput("t1_write_end",  {31'b0, bus.write_fifo}, 32'd0);
    checkOutput("t1_busy_end",   {31'b0, bus.busy}, 32'd0);
    @(negedge clk); #1;
    checkOutput("t1_sent_once",  {31'b0, bus.packet_sent}, 32'd0);

    // Back-pressure: two full cycles while flit B is presented.
    @(negedge clk);
    applyStimulus(1'b1, 32'h1234ABCD, 1'b0);
    nWrites = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, (c == 2 || c == 3));
      #1;
      checkOutput("t2_write", {31'b0, bus.write_fifo}, (c == 2 || c == 3) ? 32'd0 : 32'd1);
      checkOutput("t2_flit",  {28'b0, bus.flit_out},
                  {28'b0, seqA[(c < 2) ? c : ((c < 4) ? 2 : c - 2)]});
      if (bus.write_fifo) nWrites++;
    end
    checkOutput("t2_writes", nWrites, 32'd8);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1 checkOutput("t2_sent_pulse", {31'b0, bus.packet_sent}, 32'd1);

    // Back-to-back packets with the second held in the pending buffer.
    @(negedge clk);
    applyStimulus(1'b1, 32'h11112222, 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) applyStimulus(1'b1, 32'h33334444, 1'b0);
      else        applyStimulus(1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("t3_write", {31'b0, bus.write_fifo}, 32'd1);
      checkOutput("t3_flit",  {28'b0, bus.flit_out}, {28'b0, seqB[k]});
      checkOutput("t3_ready", {31'b0, bus.packet_ready}, (k >= 1 && k <= 7) ? 32'd0 : 32'd1);
      checkOutput("t3_sent",  {31'b0, bus.packet_sent}, (k == 8) ? 32'd1 : 32'd0);
    end
    @(negedge clk); #1;
    checkOutput("t3_sent_pulse", {31'b0, bus.packet_sent}, 32'd1);
    checkOutput("t3_busy_end",   {31'b0, bus.busy}, 32'd0);

    // FIFO full at accept and for four more cycles.
    @(negedge clk);
    applyStimulus(1'b1, 32'h1234ABCD, 1'b1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, (c < 4));
      #1;
      checkOutput("t4_write", {31'b0, bus.write_fifo}, (c < 4) ? 32'd0 : 32'd1);
      checkOutput("t4_flit",  {28'b0, bus.flit_out}, {28'b0, seqA[(c < 4) ? 0 : c - 4]});
      checkOutput("t4_busy",  {31'b0, bus.busy}, 32'd1);
    end
    @(negedge clk); #1;
    checkOutput("t4_sent_pulse", {31'b0, bus.packet_sent}, 32'd1);

    // Reset after three flits of 0xDEADBEEF with 0xCAFEF00D pending.
    @(negedge clk);
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 32'hCAFEF00D, 1'b0);
    #1 checkOutput("t5_flit0", {28'b0, bus.flit_out}, 32'hF);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1 checkOutput("t5_ready_pend", {31'b0, bus.packet_ready}, 32'd0);
    @(negedge clk); #1;
    checkOutput("t5_flit2", {28'b0, bus.flit_out}, 32'hE);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("t5_rst_write", {31'b0, bus.write_fifo}, 32'd0);
    checkOutput("t5_rst_flit",  {28'b0, bus.flit_out}, 32'd0);
    checkOutput("t5_rst_ready", {31'b0, bus.packet_ready}, 32'd1);
    checkOutput("t5_rst_busy",  {31'b0, bus.busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 32'h0000000F, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("t5_write", {31'b0, bus.write_fifo}, 32'd1);
      checkOutput("t5_flit",  {28'b0, bus.flit_out}, {28'b0, seqF[i]});
    end
    @(negedge clk); #1;
    checkOutput("t5_sent_pulse", {31'b0, bus.packet_sent}, 32'd1);
    checkOutput("t5_busy_end",   {31'b0, bus.busy}, 32'd0);

`ifdef FLIT_SERIALIZER_PKT_COUNT_EN
    checkOutput("cnt_after_reset", {16'b0, bus.sent_count}, 32'd1);
    sendPacket(32'h01234567);
    sendPacket(32'h89ABCDEF);
    checkOutput("cnt_three", {16'b0, bus.sent_count}, 32'd3);
    @(negedge clk);
    force dut.r_sent_count = 16'hFFFF;
    #1;
    release dut.r_sent_count;
    sendPacket(32'h00000001);
    checkOutput("cnt_wrap", {16'b0, bus.sent_count}, 32'd0);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
